// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Combined branch target buffer and 2-bit bimodal history table for the
// 5-stage RV32I pipeline. Fetch gets a zero-latency next-PC guess for PCF.
// The EX stage resolves the branch against the prediction flags carried
// down the pipe, raises a redirect on a wrong guess, and trains the
// tables on the clock edge.
//
// Parameters
//   ENTRIES  number of direct-mapped entries (power of two, 4..1024)
//   IDX_W    index width, index = PC[IDX_W+1:2]
//   TAG_W    tag width,   tag   = PC[31:IDX_W+2]
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   PCF                    fetch PC
//   PredNPCF               predicted next PC (target if hit and taken, else PCF+4)
//   BranchPredictedF       entry valid and tag matches PCF
//   BranchPredictedTakenF  hit and counter MSB set
//   UpdateE                EX holds a valid, non-stalled conditional branch
//   PCE                    EX PC
//   ActualTakenE           resolved direction
//   ActualTargetE          resolved target
//   PredTargetE            target predicted at fetch
//   BranchPredictedE       fetch hit flag, piped
//   BranchPredictedTakenE  fetch taken flag, piped
//   MispredictE            flush and redirect request
//   CorrectNPCE            redirect address
//
// Optional build macro BRANCH_PREDICTOR_STATS_EN adds the 32-bit outputs
// BranchCount, MispredictCount and HitCount.
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    output logic [31:0] PredNPCF,
    output logic        BranchPredictedF,
    output logic        BranchPredictedTakenF,
    input  logic        UpdateE,
    input  logic [31:0] PCE,
    input  logic        ActualTakenE,
    input  logic [31:0] ActualTargetE,
    input  logic [31:0] PredTargetE,
    input  logic        BranchPredictedE,
    input  logic        BranchPredictedTakenE,
    output logic        MispredictE,
    output logic [31:0] CorrectNPCE
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredictCount,
    output logic [31:0] HitCount
`endif
);

    // Valid bits and counters need a reset value; tags and targets do not,
    // so they live in plain arrays without reset.
    logic [ENTRIES-1:0]       valid_q;
    logic [ENTRIES-1:0][1:0]  cnt_q;
    logic [TAG_W-1:0]         tag_q    [ENTRIES];
    logic [31:0]              target_q [ENTRIES];

    logic [IDX_W-1:0] idx_f;
    logic [TAG_W-1:0] tag_f;
    logic             hit_f;
    logic [IDX_W-1:0] idx_e;
    logic [TAG_W-1:0] tag_e;
    logic             hit_e;
    logic [1:0]       cnt_e;

    assign idx_f = PCF[IDX_W+1:2];
    assign tag_f = PCF[31:IDX_W+2];
    assign idx_e = PCE[IDX_W+1:2];
    assign tag_e = PCE[31:IDX_W+2];

    // Fetch lookup: purely from current table contents, no bypass of an
    // update landing on the same edge.
    assign hit_f                 = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign BranchPredictedF      = hit_f;
    assign BranchPredictedTakenF = hit_f && cnt_q[idx_f][1];
    assign PredNPCF              = BranchPredictedTakenF ? target_q[idx_f] : PCF + 32'd4;

    // Training decides hit/miss from the table itself at the EX PC.
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign cnt_e = cnt_q[idx_e];

    // Resolution uses the flags captured at fetch, not a fresh lookup, so
    // the redirect matches what the front end actually did.
    always_comb begin
        MispredictE = 1'b0;
        CorrectNPCE = 32'd0;
        if (UpdateE) begin
            if (BranchPredictedTakenE && !ActualTakenE) begin
                MispredictE = 1'b1;
                CorrectNPCE = PCE + 32'd4;
            end else if (!BranchPredictedTakenE && ActualTakenE) begin
                MispredictE = 1'b1;
                CorrectNPCE = ActualTargetE;
            end else if (BranchPredictedTakenE && ActualTakenE &&
                         (PredTargetE != ActualTargetE)) begin
                MispredictE = 1'b1;
                CorrectNPCE = ActualTargetE;
            end
        end
    end

    // Valid bits and saturating counters. A miss that is not taken leaves
    // the entry alone; a taken miss claims the slot as weakly taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            cnt_q   <= {ENTRIES{2'b01}};
        end else if (UpdateE) begin
            if (hit_e) begin
                if (ActualTakenE) begin
                    if (cnt_e != 2'b11) cnt_q[idx_e] <= cnt_e + 2'b01;
                end else begin
                    if (cnt_e != 2'b00) cnt_q[idx_e] <= cnt_e - 2'b01;
                end
            end else if (ActualTakenE) begin
                valid_q[idx_e] <= 1'b1;
                cnt_q[idx_e]   <= 2'b10;
            end
        end
    end

    // Tag and target storage. Writes are blocked while reset is low so an
    // update edge coincident with reset has no effect at all.
    always_ff @(posedge clk) begin
        if (rst_n && UpdateE && ActualTakenE) begin
            target_q[idx_e] <= ActualTargetE;
            if (!hit_e) tag_q[idx_e] <= tag_e;
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    // Performance counters, free-running and wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BranchCount     <= 32'd0;
            MispredictCount <= 32'd0;
            HitCount        <= 32'd0;
        end else if (UpdateE) begin
            BranchCount <= BranchCount + 32'd1;
            if (MispredictE)      MispredictCount <= MispredictCount + 32'd1;
            if (BranchPredictedE) HitCount        <= HitCount + 32'd1;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{PCF[1:0], PCE[1:0]};
`else
    logic unused_ok;
    assign unused_ok = ^{PCF[1:0], PCE[1:0], BranchPredictedE};
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Combined BTB and 2-bit BHT predictor for the 5-stage RV32I pipeline.
- Provides a zero-latency next-PC prediction to IF from PCF.
- Resolves each branch in EX from the prediction flags the ID-EX segment register carries (BranchPredictedE, BranchPredictedTakenE).
- Raises a mispredict/redirect to the hazard unit and updates its tables at the EX clock edge.

Parameters:
- ENTRIES, 64, number of direct-mapped entries; power of two, 4..1024.
- IDX_W, log2(ENTRIES), index width; index = PC[IDX_W+1:2].
- TAG_W, 30-IDX_W, tag width; tag = PC[31:IDX_W+2].

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- PCF  in  32  fetch-stage PC.
- PredNPCF  out  32  predicted next PC: stored target if hit and counter>=2, else PCF+4.
- BranchPredictedF  out  1  BTB hit for PCF (valid and tag match).
- BranchPredictedTakenF  out  1  hit and counter[1]==1.
- UpdateE  in  1  EX holds a valid, non-stalled conditional branch (BranchTypeE!=0); qualified by the hazard unit.
- PCE  in  32  EX-stage PC.
- ActualTakenE  in  1  branch outcome from the branch decision unit.
- ActualTargetE  in  32  computed branch target (BrNPC).
- PredTargetE  in  32  target predicted at fetch, piped along.
- BranchPredictedE  in  1  BTB hit flag piped from fetch.
- BranchPredictedTakenE  in  1  taken prediction piped from fetch.
- MispredictE  out  1  flush IF/ID and ID/EX, redirect fetch.
- CorrectNPCE  out  32  redirect address when MispredictE=1.

Behaviour:
- Storage per entry:
  - valid bit.
  - TAG_W tag.
  - 32-bit target.
  - 2-bit saturating counter: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Lookup (combinational, 0 cycles):
  - hit = valid[idx(PCF)] && tag match.
  - All F outputs are derived from the current table contents only.
- Mispredict (combinational, valid only when UpdateE=1; otherwise MispredictE=0 and CorrectNPCE=0):
  - Predicted taken, actual not taken: MispredictE=1, CorrectNPCE=PCE+4.
  - Predicted not taken (miss or counter<2), actual taken: MispredictE=1, CorrectNPCE=ActualTargetE.
  - Predicted taken, actual taken, PredTargetE!=ActualTargetE: MispredictE=1, CorrectNPCE=ActualTargetE.
  - All other cases: MispredictE=0.
- Update (posedge clk, when UpdateE=1), at idx(PCE):
  - Hit: counter +1 if taken (saturate at 11), -1 if not taken (saturate at 00). Target overwritten with ActualTargetE when taken.
  - Miss and taken: allocate the entry (replace unconditionally). Valid=1, tag=tag(PCE), target=ActualTargetE, counter=10.
  - Miss and not taken: no change.
  - UpdateE=0: tables hold.
- Simultaneous lookup and update to the same index in one cycle:
  - Lookup returns the pre-update contents.
  - The new contents are visible from the next cycle.
  - No bypass.
- Reset (asynchronous, any cycle including mid-update):
  - All valid bits=0; all counters=01.
  - Tags and targets are don't-care.
  - Outputs immediately: BranchPredictedF=0, BranchPredictedTakenF=0, PredNPCF=PCF+4.
  - An update edge coincident with rst_n low is discarded.
- Arithmetic:
  - PC+4 wraps modulo 2^32 (0xFFFFFFFC+4 = 0).
  - PC[1:0] is ignored for index and tag.
- Only conditional branches are predicted. JAL and JALR are not entered: the hazard unit never asserts UpdateE for them.

Optional Feature:
- Macro: BRANCH_PREDICTOR_STATS_EN.
- When defined, adds three outputs:
  - BranchCount (32): +1 on every UpdateE.
  - MispredictCount (32): +1 on every UpdateE with MispredictE=1.
  - HitCount (32): +1 on every UpdateE with BranchPredictedE=1.
- Counters reset to 0 asynchronously and wrap at 2^32.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then PCF=0x00000100 -> BranchPredictedF=0, BranchPredictedTakenF=0, PredNPCF=0x00000104.
- UpdateE=1, PCE=0x100, taken, ActualTargetE=0x80, BranchPredictedE=0 -> MispredictE=1, CorrectNPCE=0x80. Next cycle PCF=0x100 -> hit, taken, PredNPCF=0x80.
- Same branch: not taken twice, then taken once -> counter 10→01→00→01. BranchPredictedTakenF=0 after the second not-taken. Each not-taken resolve with predicted-taken=1 gives CorrectNPCE=0x104.
- PCE=0x100 hit, taken, PredTargetE=0x80, ActualTargetE=0x90 -> MispredictE=1, CorrectNPCE=0x90, stored target becomes 0x90.
- ENTRIES=64: allocate 0x100, then allocate 0x200 taken (same index 0) -> lookup of 0x100 misses, lookup of 0x200 hits. Update and lookup of the same index in one cycle return the old entry.
- Assert rst_n low mid-run, coincident with UpdateE=1 -> all lookups miss afterwards and the update is discarded. With BRANCH_PREDICTOR_STATS_EN, all counters read 0.
